// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, Funct codes,
// FSM states, ALUOp selectors and ALU operation codes.
package mips_pkg;

  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_ILL = 3'b011;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEX   = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

endpackage

// File: rtl/alu_decoder.sv
// Maps ALUOp and Funct to the ALU operation code; unknown Funct under
// ALUOP_FUNCT yields ALU_ILL and raises o_funct_illegal.
module alu_decoder
  import mips_pkg::*;
(
  input  aluop_t      i_alu_op,
  input  logic [5:0]  i_funct,
  output logic [2:0]  o_alu_control,
  output logic        o_funct_illegal
);

  always_comb begin
    o_alu_control   = ALU_ADD;
    o_funct_illegal = 1'b0;
    case (i_alu_op)
      ALUOP_ADD: o_alu_control = ALU_ADD;
      ALUOP_SUB: o_alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (i_funct)
          FN_ADD:  o_alu_control = ALU_ADD;
          FN_SUB:  o_alu_control = ALU_SUB;
          FN_AND:  o_alu_control = ALU_AND;
          FN_OR:   o_alu_control = ALU_OR;
          FN_SLT:  o_alu_control = ALU_SLT;
          FN_NOR:  o_alu_control = ALU_NOR;
          default: begin
            o_alu_control   = ALU_ILL;
            o_funct_illegal = 1'b1;
          end
        endcase
      end
      default: o_alu_control = ALU_ILL;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore FSM sequencing the multicycle MIPS datapath (lw, sw, R-type, beq,
// addi, j) with illegal-opcode / illegal-Funct reporting.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic       PCEn,
  output logic       IllegalOp,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [2:0] ALUControl,
  output logic [3:0] StateDbg
);

  state_t     r_state;
  state_t     w_next;
  state_t     w_cur;
  logic       r_funct_ill;
  aluop_t     w_alu_op;
  logic       w_alu_en;
  logic [2:0] w_dec_ctrl;
  logic       w_funct_ill;
  logic       w_pcwrite;
  logic       w_branch;

  alu_decoder u_alu_decoder (
    .i_alu_op        (w_alu_op),
    .i_funct         (Funct),
    .o_alu_control   (w_dec_ctrl),
    .o_funct_illegal (w_funct_ill)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_FETCH;
      r_funct_ill <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_EXECUTE) r_funct_ill <= w_funct_ill;
    end
  end

  // Outputs during reset follow FETCH; the side-effecting strobes are masked below.
  assign w_cur    = reset ? S_FETCH : r_state;
  assign StateDbg = r_state;

  always_comb begin
    w_alu_op = ALUOP_ADD;
    w_alu_en = 1'b0;
    case (w_cur)
      S_FETCH, S_DECODE, S_MEMADR, S_ADDIEX: w_alu_en = 1'b1;
      S_EXECUTE: begin
        w_alu_op = ALUOP_FUNCT;
        w_alu_en = 1'b1;
      end
      S_BRANCH: begin
        w_alu_op = ALUOP_SUB;
        w_alu_en = 1'b1;
      end
      default: w_alu_en = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = S_FETCH;
    IorD      = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    RegDst    = 1'b0;
    MemtoReg  = 1'b0;
    RegWrite  = 1'b0;
    ALUSrcA   = 1'b0;
    IllegalOp = 1'b0;
    ALUSrcB   = 2'b00;
    PCSrc     = 2'b00;
    w_pcwrite = 1'b0;
    w_branch  = 1'b0;
    case (w_cur)
      S_FETCH: begin
        ALUSrcB   = 2'b01;
        IRWrite   = 1'b1;
        w_pcwrite = 1'b1;
        w_next    = S_DECODE;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_RTYPE:     w_next = S_EXECUTE;
          OP_BEQ:       w_next = S_BRANCH;
          OP_ADDI:      w_next = S_ADDIEX;
          OP_J:         w_next = S_JUMP;
          default:      IllegalOp = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        IorD   = 1'b1;
        w_next = S_MEMWB;
      end
      S_MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWRITE: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_EXECUTE: begin
        ALUSrcA   = 1'b1;
        IllegalOp = w_funct_ill;
        w_next    = S_ALUWB;
      end
      S_ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = ~r_funct_ill;
      end
      S_BRANCH: begin
        ALUSrcA  = 1'b1;
        PCSrc    = 2'b01;
        w_branch = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        w_next  = S_ADDIWB;
      end
      S_ADDIWB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc     = 2'b10;
        w_pcwrite = 1'b1;
      end
      default: w_next = S_FETCH;
    endcase

    ALUControl = w_alu_en ? w_dec_ctrl : 3'b000;
    PCEn       = w_pcwrite | (w_branch & Zero);

    if (reset) begin
      PCEn      = 1'b0;
      IRWrite   = 1'b0;
      MemWrite  = 1'b0;
      RegWrite  = 1'b0;
      IllegalOp = 1'b0;
    end
  end

endmodule
